// File: rtl/reduce_accumulator_if.sv
//==============================================================================
// reduce_accumulator_if : key/value input, BRAM ports and drain stream bundle
// Revision: 1.0
//==============================================================================
`default_nettype none

interface reduce_accumulator_if #(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_DEPTH = 2,
    parameter int C_VAL_WIDTH = 16
);
    logic                   kv_valid;
    logic                   kv_ready;
    logic [C_LOG_DEPTH-1:0] key;
    logic [C_VAL_WIDTH-1:0] value;
    logic                   flush;
    logic [C_LOG_DEPTH-1:0] bram_waddr;
    logic                   bram_wen;
    logic [C_WIDTH-1:0]     bram_wdata;
    logic [C_LOG_DEPTH-1:0] bram_raddr;
    logic                   bram_ce;
    logic [C_WIDTH-1:0]     bram_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [C_LOG_DEPTH-1:0] out_key;
    logic [C_WIDTH-1:0]     out_count;
    logic                   busy;
    logic                   done;

    modport slave (
        input  kv_valid, key, value, flush, bram_rdata, out_ready,
        output kv_ready, bram_waddr, bram_wen, bram_wdata, bram_raddr, bram_ce,
               out_valid, out_key, out_count, busy, done
    );

    modport master (
        output kv_valid, key, value, flush, bram_rdata, out_ready,
        input  kv_ready, bram_waddr, bram_wen, bram_wdata, bram_raddr, bram_ce,
               out_valid, out_key, out_count, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/reduce_accumulator.sv
//==============================================================================
// reduce_accumulator : saturating read-modify-write of a count table, then drain
// Revision: 1.0
//==============================================================================
`default_nettype none

module reduce_accumulator #(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_DEPTH = 2,
    parameter int C_VAL_WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    reduce_accumulator_if.slave   io
);
    typedef enum logic [1:0] {
        CLEAR      = 2'd0,
        ACCUM      = 2'd1,
        FLUSH_WAIT = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    localparam logic [C_LOG_DEPTH-1:0] c_last = '1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [C_LOG_DEPTH-1:0] r_addr;
    logic [C_LOG_DEPTH-1:0] w_addr_nxt;
    logic                   r_out_valid;
    logic                   w_out_valid_nxt;

    logic                   r_s1_valid;
    logic [C_LOG_DEPTH-1:0] r_s1_key;
    logic [C_VAL_WIDTH-1:0] r_s1_value;

    logic                   r_prev_wen;
    logic [C_LOG_DEPTH-1:0] r_prev_waddr;
    logic [C_WIDTH-1:0]     r_prev_wdata;

    logic                   w_accept;
    logic                   w_kv_ready;
    logic                   w_wen;
    logic [C_LOG_DEPTH-1:0] w_waddr;
    logic [C_WIDTH-1:0]     w_wdata;
    logic                   w_ce;
    logic [C_LOG_DEPTH-1:0] w_raddr;
    logic                   w_done;

    logic [C_WIDTH-1:0]     w_base;
    logic [C_WIDTH:0]       w_sum;
    logic [C_WIDTH-1:0]     w_sat;

    // The BRAM returns the old word when read and written on the same edge,
    // so the word written last cycle must be taken from the write register.
    always_comb begin
        w_base = (r_prev_wen && (r_prev_waddr == r_s1_key)) ? r_prev_wdata : io.bram_rdata;
        w_sum  = {1'b0, w_base} + {{(C_WIDTH + 1 - C_VAL_WIDTH){1'b0}}, r_s1_value};
        w_sat  = w_sum[C_WIDTH] ? {C_WIDTH{1'b1}} : w_sum[C_WIDTH-1:0];
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_out_valid_nxt = r_out_valid;
        w_kv_ready      = 1'b0;
        w_accept        = 1'b0;
        w_wen           = r_s1_valid;
        w_waddr         = r_s1_valid ? r_s1_key : '0;
        w_wdata         = r_s1_valid ? w_sat : '0;
        w_ce            = 1'b0;
        w_raddr         = '0;
        w_done          = 1'b0;

        case (r_state)
            CLEAR: begin
                w_wen      = rst_n;
                w_waddr    = r_addr;
                w_wdata    = '0;
                w_addr_nxt = r_addr + 1'b1;
                if (r_addr == c_last) begin
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                w_kv_ready = 1'b1;
                w_accept   = io.kv_valid;
                w_ce       = io.kv_valid;
                w_raddr    = io.kv_valid ? io.key : '0;
                if (io.flush) begin
                    w_state_nxt = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (!r_s1_valid) begin
                    w_state_nxt = DRAIN;
                    w_addr_nxt  = '0;
                end
            end
            DRAIN: begin
                w_raddr = r_addr;
                if (!r_out_valid) begin
                    w_ce            = 1'b1;
                    w_out_valid_nxt = 1'b1;
                end else if (io.out_ready) begin
                    // Zero the entry as it leaves so the next round starts clean.
                    w_wen   = 1'b1;
                    w_waddr = r_addr;
                    w_wdata = '0;
                    if (r_addr == c_last) begin
                        w_done          = 1'b1;
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = ACCUM;
                    end else begin
                        w_ce       = 1'b1;
                        w_raddr    = r_addr + 1'b1;
                        w_addr_nxt = r_addr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= CLEAR;
            r_addr       <= '0;
            r_out_valid  <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_key     <= '0;
            r_s1_value   <= '0;
            r_prev_wen   <= 1'b0;
            r_prev_waddr <= '0;
            r_prev_wdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_s1_valid   <= w_accept;
            r_s1_key     <= io.key;
            r_s1_value   <= io.value;
            r_prev_wen   <= w_wen;
            r_prev_waddr <= w_waddr;
            r_prev_wdata <= w_wdata;
        end
    end

    assign io.kv_ready   = w_kv_ready;
    assign io.bram_wen   = w_wen;
    assign io.bram_waddr = w_waddr;
    assign io.bram_wdata = w_wdata;
    assign io.bram_ce    = w_ce;
    assign io.bram_raddr = w_raddr;
    assign io.out_valid  = r_out_valid;
    assign io.out_key    = r_addr;
    assign io.out_count  = io.bram_rdata;
    assign io.busy       = (r_state != ACCUM) || r_s1_valid;
    assign io.done       = w_done;

endmodule

`default_nettype wire
